// File: rtl/multicycle_main_control.sv
// multicycle_main_control: opcode-driven FSM sequencing fetch/decode/execute/memory/writeback
// and decoding all datapath enables, mux selects and AluOP from the state register.
module multicycle_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] AluOP,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECUTE  = 4'd7,
        RTYPE_WB = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                                (opcode == OP_RTYPE) ? EXECUTE :
                                (opcode == OP_BEQ)   ? BRANCH :
                                (opcode == OP_J)     ? JUMP : FETCH;
            MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD :
                                (opcode == OP_SW) ? MEMWRITE : FETCH;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTE:  state_d = RTYPE_WB;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;

    // Moore decode; only the FETCH-cycle PC/IR loads wait on the memory handshake
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        AluOP       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                               opcode == OP_BEQ || opcode == OP_J);
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                AluOP   = 2'b10;
            end
            RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                AluOP       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: directed state-by-state checks of the main control FSM
// against hand-written per-state output vectors.
module tb_multicycle_main_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, AluOP, PCSource;
    logic [3:0] state;
    int         n_cmp = 0;
    int         n_err = 0;

    multicycle_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOP(AluOP),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,AluOP,PCSource,illegal_op}
    logic [16:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, AluOP, PCSource, illegal_op};

    localparam logic [16:0] E_IDLE = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] E_FET1 = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] E_FET0 = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] E_DEC  = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] E_DECI = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] E_MADR = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] E_MRD  = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] E_MWB  = 17'b0000001010_00_00_00_0;
    localparam logic [16:0] E_MWR  = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] E_EXE  = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] E_RWB  = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] E_BR   = 17'b0100000001_00_01_01_0;
    localparam logic [16:0] E_JMP  = 17'b1000000000_00_00_10_0;

    // Inputs change and outputs are sampled at the falling edge, away from the active edge
    task automatic cyc(input string tag, input logic [3:0] es, input logic [16:0] eo);
        #1;
        n_cmp++;
        assert (state === es) else begin
            n_err++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
        n_cmp++;
        assert (obs === eo) else begin
            n_err++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs, eo);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        cyc("reset", 4'd0, E_IDLE);
        rst = 1'b0;
        cyc("r_idle", 4'd0, E_IDLE);
        cyc("r_fetch", 4'd1, E_FET1);
        cyc("r_decode", 4'd2, E_DEC);
        cyc("r_exec", 4'd7, E_EXE);
        cyc("r_wb", 4'd8, E_RWB);
        opcode = 6'b100011;
        cyc("lw_fetch", 4'd1, E_FET1);
        cyc("lw_decode", 4'd2, E_DEC);
        cyc("lw_madr", 4'd3, E_MADR);
        mem_ready = 1'b0;
        cyc("lw_wait0", 4'd4, E_MRD);
        cyc("lw_wait1", 4'd4, E_MRD);
        mem_ready = 1'b1;
        cyc("lw_read", 4'd4, E_MRD);
        cyc("lw_wb", 4'd5, E_MWB);
        mem_ready = 1'b0;
        opcode = 6'b101011;
        cyc("fw_wait0", 4'd1, E_FET0);
        cyc("fw_wait1", 4'd1, E_FET0);
        cyc("fw_wait2", 4'd1, E_FET0);
        mem_ready = 1'b1;
        cyc("sw_fetch", 4'd1, E_FET1);
        cyc("sw_decode", 4'd2, E_DEC);
        cyc("sw_madr", 4'd3, E_MADR);
        cyc("sw_write", 4'd6, E_MWR);
        opcode = 6'b000100;
        cyc("beq_fetch", 4'd1, E_FET1);
        cyc("beq_decode", 4'd2, E_DEC);
        mem_ready = 1'b0;
        cyc("beq_branch", 4'd9, E_BR);
        mem_ready = 1'b1;
        opcode = 6'b000010;
        cyc("j_fetch", 4'd1, E_FET1);
        cyc("j_decode", 4'd2, E_DEC);
        mem_ready = 1'b0;
        cyc("j_jump", 4'd10, E_JMP);
        cyc("j_fetchwait", 4'd1, E_FET0);
        mem_ready = 1'b1;
        opcode = 6'b111111;
        cyc("ill_fetch", 4'd1, E_FET1);
        cyc("ill_decode", 4'd2, E_DECI);
        opcode = 6'b100011;
        cyc("rst_fetch", 4'd1, E_FET1);
        cyc("rst_decode", 4'd2, E_DEC);
        cyc("rst_madr", 4'd3, E_MADR);
        mem_ready = 1'b0;
        cyc("rst_wait", 4'd4, E_MRD);
        rst = 1'b1;
        cyc("rst_assert", 4'd4, E_MRD);
        cyc("rst_idle", 4'd0, E_IDLE);
        rst = 1'b0;
        cyc("rst_release", 4'd0, E_IDLE);
        cyc("rst_refetch", 4'd1, E_FET0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle datapath. Sits directly upstream of ALU control.
- Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Drives all datapath enables, mux selects and the 2-bit AluOP consumed by ALU control.
- Waits on a memory-ready handshake for every memory access.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory has completed the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data select: 1 = MDR
RegDst  output  1  destination register select: 1 = rd, 0 = rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
AluOP  output  2  00 = add, 01 = subtract (branch), 10 = R-type funct; 11 is never driven
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  high during DECODE when opcode is unrecognised
state  output  4  current state encoding, for debug and bench

Behaviour:
- Moore outputs decoded from the state register. Exceptions are PCWrite and IRWrite in FETCH, which are qualified by mem_ready.
- Any output not listed for a state is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, RTYPE_WB=8, BRANCH=9, JUMP=10. Encodings 11-15 are unreachable and go to FETCH.
- Reset: while rst=1 at a clock edge, state becomes IDLE, overriding any in-progress transition, including a mid-memory wait. In IDLE all outputs are 0 and state=0.
- IDLE: outputs all 0. Next state: FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00; IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, AluOP=00. Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - J -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this single cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOP=00. Next state: LW -> MEMREAD, SW -> MEMWRITE. Opcode is held stable by IR.
- MEMREAD: MemRead=1, IorD=1. Holds while mem_ready=0; goes to MEMWB on mem_ready=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Holds while mem_ready=0; goes to FETCH on mem_ready=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, AluOP=10. Next state: RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01. Next state: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state: FETCH.
- Latency with mem_ready tied high:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
  - Illegal opcode: 2 cycles
- Each memory wait cycle adds 1 cycle.
- mem_ready is ignored in all non-memory states.
- MemRead and MemWrite are never both 1.
- RegWrite and PCWrite are never both 1.

Test Plan:
- Reset then R-type: rst high 2 cycles, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1; AluOP=10 in state 7; RegWrite=1 and RegDst=1 only in state 8.
- LW with 2-cycle memory wait in MEMREAD: mem_ready=0 for 2 cycles in state 4 -> state held at 4 with MemRead=1, IorD=1; then 5 with MemtoReg=1, RegWrite=1; then 1; total 7 cycles from FETCH.
- FETCH wait: mem_ready=0 for 3 cycles -> state stays 1; IRWrite=PCWrite=0 throughout; both go to 1 only in the cycle mem_ready=1.
- SW then BEQ then J back-to-back, mem_ready=1 -> states 1,2,3,6,1,2,9,1,2,10,1; AluOP=01 and PCWriteCond=1 in state 9; PCSource=10 and PCWrite=1 in state 10.
- Illegal opcode 111111 -> state 1,2,1; illegal_op=1 for exactly one cycle in state 2; RegWrite, MemWrite and PCWrite stay 0.
- Reset mid-operation: assert rst while in state 4 with mem_ready=0 -> next state 0, all outputs 0; after rst drops, state 1.
